// File: rtl/shifter_seq_if.sv
// Request/result bundle for the sequential shifter.
// The master drives the request fields; the slave returns the result and status.
interface shifter_seq_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             start;
   logic [2:0]       mode;
   logic [SHW-1:0]   amount;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] H;
   logic             C;
   logic             Z;
   logic             busy;
   logic             done;

   modport master (
      output start, mode, amount, B,
      input  H, C, Z, busy, done
   );

   modport slave (
      input  start, mode, amount, B,
      output H, C, Z, busy, done
   );
endinterface

// File: rtl/shifter_seq.sv
// Iterative shift unit: captures an operand on start, then shifts up to STEP
// positions per clock, pulsing done when the registered H/C/Z are updated.
module shifter_seq #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input logic         clk,
   input logic         rst,
   shifter_seq_if.slave bus
);
   localparam int          SHW    = $clog2(WIDTH);
   localparam int unsigned STEP_U = STEP;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [2:0]       mode_r;
   logic [SHW-1:0]   rem;
   logic             carry;

   logic [WIDTH-1:0] work_nxt;
   logic             carry_nxt;
   logic [SHW-1:0]   rem_nxt;
   logic             pass_op;
   logic             accept;

   // Modes 000, 110 and 111 all pass the operand through untouched.
   assign pass_op = (bus.mode == 3'b000) || (bus.mode[2:1] == 2'b11);
   assign accept  = bus.start && (state != SHIFT);

   // One clock's worth of shifting, unrolled as single-bit steps gated by rem.
   always_comb begin
      work_nxt  = work;
      carry_nxt = carry;
      for (int unsigned i = 0; i < STEP_U; i++) begin
         if (i < 32'(rem)) begin
            unique case (mode_r)
               3'b001: begin
                  carry_nxt = work_nxt[0];
                  work_nxt  = {1'b0, work_nxt[WIDTH-1:1]};
               end
               3'b010: begin
                  carry_nxt = work_nxt[WIDTH-1];
                  work_nxt  = {work_nxt[WIDTH-2:0], 1'b0};
               end
               3'b011: begin
                  carry_nxt = work_nxt[0];
                  work_nxt  = {work_nxt[WIDTH-1], work_nxt[WIDTH-1:1]};
               end
               3'b100: begin
                  carry_nxt = work_nxt[0];
                  work_nxt  = {work_nxt[0], work_nxt[WIDTH-1:1]};
               end
               3'b101: begin
                  carry_nxt = work_nxt[WIDTH-1];
                  work_nxt  = {work_nxt[WIDTH-2:0], work_nxt[WIDTH-1]};
               end
               default: ;
            endcase
         end
      end
      rem_nxt = (rem < SHW'(STEP)) ? '0 : rem - SHW'(STEP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         work     <= '0;
         mode_r   <= '0;
         rem      <= '0;
         carry    <= 1'b0;
         bus.H    <= '0;
         bus.C    <= 1'b0;
         bus.Z    <= 1'b1;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else if (accept) begin
         work   <= bus.B;
         mode_r <= bus.mode;
         rem    <= bus.amount;
         carry  <= 1'b0;
         if (pass_op || (bus.amount == '0)) begin
            state    <= DONE;
            bus.H    <= bus.B;
            bus.C    <= 1'b0;
            bus.Z    <= (bus.B == '0);
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
         end else begin
            state    <= SHIFT;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
         end
      end else begin
         unique case (state)
            SHIFT: begin
               work  <= work_nxt;
               carry <= carry_nxt;
               rem   <= rem_nxt;
               if (rem_nxt == '0) begin
                  state    <= DONE;
                  bus.H    <= work_nxt;
                  bus.C    <= carry_nxt;
                  bus.Z    <= (work_nxt == '0);
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/shifter_seq.md
# shifter_seq

Parametrised sequential shift unit for the function-unit datapath, succeeding the fixed 32-bit combinational shifter. It accepts an operand, a shift mode and a shift amount on a start pulse, then shifts iteratively by up to STEP positions per clock. It reports completion with a one-cycle done pulse and holds the result, carry-out and zero flags until the next completion.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2.
- STEP, 1, maximum positions shifted per clock; 1 ≤ STEP ≤ WIDTH-1.
- SHW, $clog2(WIDTH), width of the amount field (derived, not overridden).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge of clk.
- mode  input  3  shift mode, captured with start.
- amount  input  SHW  shift count 0..WIDTH-1, captured with start.
- B  input  WIDTH  operand, captured with start.
- H  output  WIDTH  registered result.
- C  output  1  registered carry: the last bit shifted out.
- Z  output  1  registered zero flag, (H == 0).
- busy  output  1  high while shifting is in progress.
- done  output  1  one-cycle completion pulse.

## Operation
- Mode encoding:
  - 000 pass.
  - 001 LSR, zero fill from the MSB.
  - 010 LSL, zero fill from the LSB.
  - 011 ASR, sign fill.
  - 100 ROR.
  - 101 ROL.
  - 110 and 111 behave as pass.
- The FSM has three states: IDLE, SHIFT, DONE.
- start is accepted in IDLE and in DONE. It is ignored in SHIFT; no queuing.
- On acceptance, B, mode and amount are loaded into internal working registers.
  - Pass mode, or amount = 0: go directly to DONE. Result = B, C = 0.
  - Otherwise: go to SHIFT with remaining = amount.
- In SHIFT, each edge shifts the working value by k = min(STEP, remaining) positions and decrements remaining by k.
  - The carry register takes the last bit shifted out.
  - For rotates, that is the bit that wrapped last.
  - When remaining reaches 0, the state goes to DONE.
- Entry to DONE loads H from the working value, and C and Z with it. H, C and Z change at no other time except reset.
- DONE lasts exactly one cycle.
  - If start is high during DONE, a new operation is accepted at that edge.
  - Otherwise the state returns to IDLE.
- Arithmetic rules:
  - ASR fills with the captured B[WIDTH-1].
  - LSL or LSR by WIDTH-1 leaves a single surviving bit.
  - Rotates preserve the popcount.
  - amount never reaches WIDTH by construction.
- Reset asserted at any time, including mid-SHIFT:
  - Aborts the operation and forces IDLE.
  - H = 0, C = 0, Z = 1, busy = 0, done = 0.
  - Working registers are cleared.

## Timing
- Reset values: H = 0, C = 0, Z = 1, busy = 0, done = 0, state = IDLE.
- Latency: with start sampled at edge 0, done is high in cycle ceil(amount/STEP)+1.
  - Pass, or amount 0: 1 cycle.
  - STEP = 1, amount A: A+1 cycles.
- busy = (state == SHIFT), a registered decode. busy is 0 in the DONE cycle.
- H, C and Z become valid in the same cycle done rises and stay stable until the next DONE entry.
- Back-to-back throughput: one operation per ceil(amount/STEP)+1 cycles. The DONE cycle overlaps the next acceptance.
- mode, amount and B may change freely after the accepting edge.

## Test plan
- Reset check: assert rst mid-stream, then release. Required: H = 0, C = 0, Z = 1, busy = 0, done = 0 immediately and after release.
- WIDTH = 32, STEP = 1, B = 0x80000000:
  - LSR 1 -> H = 0x40000000, C = 0, done in cycle 2.
  - LSL 1 -> H = 0, C = 1, Z = 1.
  - Pass -> H = 0x80000000, done in cycle 1.
- STEP = 1, B = 0x80000000, ASR 4 -> H = 0xF8000000, C = 0, busy high for cycles 1..4, done in cycle 5.
- STEP = 4:
  - B = 0x00000030, ROR 6 -> H = 0xC0000000, C = 1, done in cycle 3.
  - B = 0x80000001, ROL 1 -> H = 0x00000003, C = 1.
- Handshake:
  - start pulsed during SHIFT -> ignored; result matches the first request.
  - start held during DONE -> the second operation is accepted with no idle cycle.
  - rst pulsed mid-SHIFT -> no done pulse; H = 0.
- mode = 111, amount = 5, B = 0x12345678 -> H = 0x12345678, C = 0, Z = 0, done in cycle 1.
